// File: rtl/and2_sweep_checker.sv
// and2_sweep_checker: sweeps 00,01,10,11 onto an AND gate and counts result mismatches.
// Optional AND2_FAIL_CAPTURE_EN adds a first-failure capture (fail_valid/fail_a/fail_b).
module and2_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             result,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef AND2_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic             fail_a,
  output logic             fail_b
`endif
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(NUM_PASSES + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    npass_q, npass_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             mismatch;
  always_comb begin
    mismatch = result != (vec_q[1] & vec_q[0]);
    err_inc  = (mismatch && err_q != '1) ? err_q + 1'b1 : err_q;
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    npass_d  = npass_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = WAIT;
        vec_d    = '0;
        npass_d  = '0;
        settle_d = SW'(SETTLE_CYCLES);
        err_d    = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        pass_d   = 1'b0;
      end
      WAIT: begin
        settle_d = settle_q - 1'b1;
        state_d  = (settle_q == SW'(1)) ? SAMPLE : WAIT;
      end
      SAMPLE: begin
        err_d    = err_inc;
        settle_d = SW'(SETTLE_CYCLES);
        state_d  = WAIT;
        vec_d    = vec_q + 1'b1;
        if (vec_q == 2'd3) begin
          if (npass_q == PW'(NUM_PASSES - 1)) begin
            // Final vector of final pass: hold 11 on a/b while reporting.
            state_d = DONE;
            vec_d   = vec_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = err_inc == '0;
          end else begin
            npass_d = npass_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      npass_q  <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      npass_q  <= npass_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end
  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef AND2_FAIL_CAPTURE_EN
  logic       fv_q, fv_d;
  logic [1:0] fab_q, fab_d;
  logic       accept;
  always_comb begin
    accept = start && (state_q == IDLE || state_q == DONE);
    fv_d   = accept ? 1'b0 : fv_q;
    fab_d  = accept ? 2'b00 : fab_q;
    if (state_q == SAMPLE && mismatch && !fv_q) begin
      fv_d  = 1'b1;
      fab_d = vec_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q  <= 1'b0;
      fab_q <= 2'b00;
    end else begin
      fv_q  <= fv_d;
      fab_q <= fab_d;
    end
  end
  assign fail_valid = fv_q;
  assign fail_a     = fab_q[1];
  assign fail_b     = fab_q[0];
`endif
endmodule

// File: tb/tb_and2_sweep_checker.sv
// tb_and2_sweep_checker: scoreboard bench for and2_sweep_checker (defaults plus a saturation instance).
module tb_and2_sweep_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic a, b, busy, done, pass_o, result;
  logic [3:0] err;
  logic a2, b2, busy2, done2, pass2;
  logic [3:0] err2;
`ifdef AND2_FAIL_CAPTURE_EN
  logic fv, fa, fb, fv2, fa2, fb2;
`endif
  always #5 clk = ~clk;
  // mode 0: real AND gate, 1: stuck-at-0, 2: stuck-at-1
  assign result = (mode == 2'd0) ? (a & b) : (mode == 2'd2);
  and2_sweep_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .result(result),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass_o), .err_count(err)
`ifdef AND2_FAIL_CAPTURE_EN
    , .fail_valid(fv), .fail_a(fa), .fail_b(fb)
`endif
  );
  and2_sweep_checker #(.SETTLE_CYCLES(3), .NUM_PASSES(8), .ERR_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .result(1'b1),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef AND2_FAIL_CAPTURE_EN
    , .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2)
`endif
  );
  int checks = 0, passed = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [3:0] err; logic pass; int edge_n;} exp_t;
  exp_t sb[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_latency", cyc, e.edge_n);
        chk("err_count", int'(err), int'(e.err));
        chk("pass", int'(pass_o), int'(e.pass));
      end
    end
    done_prev = done;
  end
  task automatic do_start(input logic [3:0] e_err, input logic e_pass, input bit push);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) sb.push_back('{e_err, e_pass, cyc + 8});
  endtask
  task automatic wait_sb();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", sb.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s, n;
    #1;
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    do_start(4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ab_seq", {a, b}, i / 2);
      chk("busy_in_sweep", busy, 1);
    end
    wait_sb();
    chk("done_ab_hold", {a, b}, 3);
    mode = 2'd1;
    do_start(4'd1, 1'b0, 1'b1);
    wait_sb();
`ifdef AND2_FAIL_CAPTURE_EN
    chk("cap0_valid", fv, 1);
    chk("cap0_ab", {fa, fb}, 3);
`endif
    mode = 2'd2;
    do_start(4'd3, 1'b0, 1'b1);
    wait_sb();
`ifdef AND2_FAIL_CAPTURE_EN
    chk("cap1_valid", fv, 1);
    chk("cap1_ab", {fa, fb}, 0);
`endif
    mode = 2'd0;
    do_start(4'd0, 1'b1, 1'b1);
`ifdef AND2_FAIL_CAPTURE_EN
    chk("cap_cleared", fv, 0);
`endif
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_sb();
    do_start(4'd0, 1'b1, 1'b1);
    chk("restart_done_low", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_ab", {a, b}, 0);
    wait_sb();
    do_start(4'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_ab", {a, b}, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ab", {a, b}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    do_start(4'd0, 1'b1, 1'b1);
    wait_sb();
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    s = cyc;
    n = 0;
    while (!done2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sat_latency", cyc, s + 128);
    chk("sat_err", err2, 15);
    chk("sat_pass", pass2, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/and2_sweep_checker.md
Name: and2_sweep_checker

Overview:
- Self-checking stimulus stage that sits directly upstream of the 2-input AND gate and also consumes its output.
- Walks the four input vectors (00, 01, 10, 11) onto the gate's a/b inputs and waits a programmable settle time per vector.
- Samples the gate's result and compares it against the expected a & b, accumulating a mismatch count.
- Gives hardware self-test of the gate without a simulation-only bench.

Parameters:
SETTLE_CYCLES, 1, cycles a vector is held before result is sampled; legal range >=1
NUM_PASSES, 1, number of full 4-vector sweeps per start; legal range >=1
ERR_W, 4, width of err_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a test; ignored while busy
result  input  1  output of the gate under test
a  output  1  gate input a, registered
b  output  1  gate input b, registered
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until the next accepted start or reset
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  ERR_W  number of mismatches, saturating

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0; internal vector, settle and pass counters cleared.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE with start=1 at a rising edge:
  - err_count<=0, done<=0, pass<=0, busy<=1.
  - vector<=0, so a=0 and b=0; pass counter<=0.
  - settle counter<=SETTLE_CYCLES; go to WAIT.
- WAIT: decrement the settle counter each cycle and hold a/b stable. After SETTLE_CYCLES cycles, go to SAMPLE.
- SAMPLE, one cycle: at the exiting edge, compare result against (a & b).
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - If vector != 3: vector increments; a=vector[1], b=vector[0] at the same edge; settle counter reloads; go to WAIT.
  - If vector == 3 and more passes remain: vector<=0, pass counter increments; go to WAIT.
  - If vector == 3 on the final pass: go to DONE; busy<=0, done<=1, pass<=(final err_count==0). The final compare is included in pass.
- Latency: done rises exactly NUM_PASSES*4*(SETTLE_CYCLES+1) rising edges after the edge that accepted start. With the defaults, that is 8 edges.
- Each vector is presented for SETTLE_CYCLES+1 cycles. a/b change only at SAMPLE exits and at start acceptance.
- start while busy: ignored, with no effect on state or counters.
- start in DONE: restarts immediately, as from IDLE.
- DONE with a/b: hold the last vector (11) until the next start or reset.
- Reset asserted mid-sweep: immediate return to the reset values above. No partial done or pass is reported.
- result is treated as synchronous to clk. The gate under test is combinational; no synchroniser is required.

Optional Feature:
Macro AND2_FAIL_CAPTURE_EN.
- Defined: adds output ports fail_valid (1), fail_a (1) and fail_b (1).
  - At the first mismatch since start, fail_valid<=1 and fail_a/fail_b<=the a/b of the failing vector.
  - These are held until the next accepted start or reset, which clear all three to 0.
  - Later mismatches do not overwrite the capture.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, result driven by a real a&b, one start pulse -> done rises 8 edges after acceptance; err_count=0, pass=1; a/b observed sequence 00,01,10,11, each held 2 cycles.
- Defaults, result stuck at 0 -> err_count=1 (vector 11 fails), pass=0; with AND2_FAIL_CAPTURE_EN, fail_valid=1, fail_a=1, fail_b=1.
- SETTLE_CYCLES=3, result stuck at 1 -> err_count=3, pass=0, done after 16 edges; with capture enabled, the captured vector is 00.
- NUM_PASSES=8, ERR_W=4, result stuck at 1 -> 24 raw mismatches; err_count saturates at 15; done after 64 edges.
- Second start asserted 3 cycles into a sweep -> ignored; done still at edge 8 with err_count=0. Then start in DONE -> done drops next edge and the sweep restarts at vector 00.
- rst_n pulsed low during the WAIT of vector 10 -> outputs immediately a=0, b=0, busy=0, done=0, err_count=0; a subsequent start completes normally with pass=1.
